// File: rtl/flash_be_slave.sv
// SPI mode-0 flash responder: decodes WREN/WRDI/BE/RDSR, keeps WEL/WIP and
// runs a timed bulk erase. All SPI inputs are oversampled on sys_clk.
module flash_be_slave #(
    parameter int ERASE_CYCLES = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic wel,
    output logic wip,
    output logic be_start,
    output logic be_done
);

    localparam int CNT_W = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, CMD, RDSR_OUT, DISCARD} state_t;

    logic [1:0]       sck_sync_q, cs_sync_q, mosi_sync_q;
    logic             sck_prev_q, cs_prev_q;
    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_in_q, shift_in_d;
    logic [7:0]       shift_out_q, shift_out_d;
    logic [2:0]       out_cnt_q, out_cnt_d;
    logic             miso_q, miso_d;
    logic             wel_q, wel_d;
    logic             wip_q, wip_d;
    logic             be_start_q, be_start_d;
    logic             be_done_q, be_done_d;
    logic [CNT_W-1:0] erase_cnt_q, erase_cnt_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            out_cnt_q   <= '0;
            miso_q      <= 1'b0;
            wel_q       <= 1'b0;
            wip_q       <= 1'b0;
            be_start_q  <= 1'b0;
            be_done_q   <= 1'b0;
            erase_cnt_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            out_cnt_q   <= out_cnt_d;
            miso_q      <= miso_d;
            wel_q       <= wel_d;
            wip_q       <= wip_d;
            be_start_q  <= be_start_d;
            be_done_q   <= be_done_d;
            erase_cnt_q <= erase_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        out_cnt_d   = out_cnt_q;
        miso_d      = miso_q;
        wel_d       = wel_q;
        wip_d       = wip_q;
        erase_cnt_d = erase_cnt_q;
        be_start_d  = 1'b0;
        be_done_d   = 1'b0;

        if (cs_rise) begin
            state_d = IDLE;
            // Only a complete single-byte frame executes, and never during an erase.
            if (state_q == CMD && bit_cnt_q == 4'd8 && !wip_q) begin
                case (shift_in_q)
                    8'h06: wel_d = 1'b1;
                    8'h04: wel_d = 1'b0;
                    8'hC7: if (wel_q) begin
                        wip_d       = 1'b1;
                        erase_cnt_d = CNT_LOAD;
                        be_start_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d    = CMD;
                    bit_cnt_d  = '0;
                    shift_in_d = '0;
                end
                CMD: if (sck_rise) begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d = DISCARD;
                    end else begin
                        shift_in_d = {shift_in_q[6:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && {shift_in_q[6:0], mosi_s} == 8'h05) begin
                            state_d     = RDSR_OUT;
                            shift_out_d = {6'b0, wel_q, wip_q};
                            out_cnt_d   = '0;
                        end
                    end
                end
                RDSR_OUT: if (sck_fall) begin
                    miso_d = shift_out_q[7];
                    // Reload on the byte's last fall so the next MSB is ready for its first rise.
                    if (out_cnt_q == 3'd7) begin
                        shift_out_d = {6'b0, wel_q, wip_q};
                        out_cnt_d   = '0;
                    end else begin
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                        out_cnt_d   = out_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if (state_d != RDSR_OUT) miso_d = 1'b0;

        if (wip_q) begin
            if (erase_cnt_q == '0) begin
                wip_d     = 1'b0;
                wel_d     = 1'b0;
                be_done_d = 1'b1;
            end else begin
                erase_cnt_d = erase_cnt_q - CNT_ONE;
            end
        end
    end

    assign miso     = miso_q;
    assign wel      = wel_q;
    assign wip      = wip_q;
    assign be_start = be_start_q;
    assign be_done  = be_done_q;

endmodule
